// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RISC-V core and its run-control unit.
package cpu_pkg;

  localparam int RC_STATE_W = 2;

  // Run-control state encoding, visible on the debug bus as a 2-bit field.
  typedef enum logic [RC_STATE_W-1:0] {
    RC_HALT  = 2'd0,
    RC_RUN   = 2'd1,
    RC_STEP  = 2'd2,
    RC_COUNT = 2'd3
  } rc_state_e;

  // PC the core starts fetching from after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // Debug read-mux codes for the run-control registers.
  localparam logic [3:0] CHK_INSTR_CNT = 4'h8;
  localparam logic [3:0] CHK_RC_STATUS = 4'h9;

  // Packs the run-control status bits the way the debug mux presents them.
  function automatic logic [31:0] rc_status_word(input logic bp_hit,
                                                 input logic halted,
                                                 input logic [RC_STATE_W-1:0] state);
    return {28'd0, bp_hit, halted, state};
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Command/status bundle between the board/debug host and the run-control unit.
interface run_ctrl_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic                  cmd_run;
  logic                  cmd_step;
  logic                  cmd_count;
  logic [CNT_W-1:0]      cnt_val;
  logic                  cmd_halt;
  logic                  cmd_clr;
  logic                  bp_en;
  logic [31:0]           bp_addr;
  logic [31:0]           pc;
  logic                  cpu_en;
  logic                  halted;
  logic                  bp_hit;
  logic [CNT_W-1:0]      instr_cnt;
  logic [RC_STATE_W-1:0] state;

  // Host side: issues commands and supplies the core PC.
  modport master (
    output cmd_run, cmd_step, cmd_count, cnt_val, cmd_halt, cmd_clr,
    output bp_en, bp_addr, pc,
    input  cpu_en, halted, bp_hit, instr_cnt, state
  );

  // Run-control side.
  modport slave (
    input  cmd_run, cmd_step, cmd_count, cnt_val, cmd_halt, cmd_clr,
    input  bp_en, bp_addr, pc,
    output cpu_en, halted, bp_hit, instr_cnt, state
  );

endinterface

// File: rtl/run_ctrl.sv
// Run-control unit: sequences the core's execute enable through halt, free
// run, single step and run-N modes, with a PC breakpoint and retire counter.
module run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned START_RUN = 0,
  parameter int          CNT_W     = 32
) (
  input  logic     clk,
  input  logic     rst,
  run_ctrl_if.slave bus
);

  localparam rc_state_e        RESET_STATE = (START_RUN != 0) ? RC_RUN : RC_HALT;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  rc_state_e        state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             resume_q, resume_d;
  logic             bp_hit_q, bp_hit_d;

  logic             in_free_run;
  logic             brk;
  logic             cpu_en;

  // Breakpoint match and execute enable; resume masks the match for the first
  // enabled cycle after leaving halt so a stopped breakpoint can be continued.
  always_comb begin
    in_free_run = (state_q == RC_RUN) || (state_q == RC_COUNT);
    brk         = in_free_run && bus.bp_en && (bus.pc == bus.bp_addr) && !resume_q;
    cpu_en      = (state_q == RC_STEP) || (in_free_run && !brk);
  end

  // Next-state, run-N countdown and resume flag.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    resume_d = cpu_en ? 1'b0 : resume_q;
    unique case (state_q)
      RC_HALT: begin
        if (!bus.cmd_halt) begin
          if (bus.cmd_step) begin
            state_d  = RC_STEP;
            resume_d = 1'b1;
          end else if (bus.cmd_count && (bus.cnt_val != '0)) begin
            state_d  = RC_COUNT;
            remain_d = bus.cnt_val;
            resume_d = 1'b1;
          end else if (bus.cmd_run) begin
            state_d  = RC_RUN;
            resume_d = 1'b1;
          end
        end
      end
      RC_RUN: begin
        if (bus.cmd_halt || brk) begin
          state_d = RC_HALT;
        end
      end
      RC_STEP: begin
        state_d = RC_HALT;
      end
      RC_COUNT: begin
        if (cpu_en) begin
          remain_d = remain_q - CNT_ONE;
        end
        if (bus.cmd_halt || brk || (cpu_en && (remain_q == CNT_ONE))) begin
          state_d = RC_HALT;
        end
      end
      default: begin
        state_d = RC_HALT;
      end
    endcase
  end

  // Retire counter and sticky breakpoint flag; clear wins over increment/set.
  always_comb begin
    instr_cnt_d = instr_cnt_q + (cpu_en ? CNT_ONE : '0);
    bp_hit_d    = bp_hit_q | brk;
    if (bus.cmd_clr) begin
      instr_cnt_d = '0;
      bp_hit_d    = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      remain_q    <= '0;
      resume_q    <= 1'b1;
      instr_cnt_q <= '0;
      bp_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      resume_q    <= resume_d;
      instr_cnt_q <= instr_cnt_d;
      bp_hit_q    <= bp_hit_d;
    end
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.halted    = (state_q == RC_HALT);
  assign bus.bp_hit    = bp_hit_q;
  assign bus.instr_cnt = instr_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized command
// traffic, checked every cycle against a behavioural model of the run modes.
module tb_run_ctrl;
  import cpu_pkg::*;

  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;

  run_ctrl_if #(.CNT_W(CW)) bus ();
  run_ctrl_if #(.CNT_W(4))  wif ();

  run_ctrl #(.START_RUN(0), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  run_ctrl #(.START_RUN(1), .CNT_W(4)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (wif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_seen = 0;

  // Behavioural model: mode, instructions left in run-N, "just resumed" flag,
  // retired count and sticky hit.
  rc_state_e         m_mode;
  logic [CW-1:0]     m_left;
  bit                m_fresh;
  logic [CW-1:0]     m_cnt;
  bit                m_hit;
  bit                m_last_en;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_break();
    return ((m_mode == RC_RUN) || (m_mode == RC_COUNT)) && bus.bp_en &&
           (bus.pc == bus.bp_addr) && !m_fresh;
  endfunction

  function automatic bit m_exec();
    if (m_mode == RC_STEP) return 1'b1;
    if ((m_mode == RC_RUN) || (m_mode == RC_COUNT)) return !m_break();
    return 1'b0;
  endfunction

  // Model advances on every clock edge from the commands seen at that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = RC_HALT; m_left = '0; m_fresh = 1'b1;
      m_cnt = '0; m_hit = 1'b0; m_last_en = 1'b0;
    end else begin
      bit e, b;
      e = m_exec();
      b = m_break();
      m_last_en = e;
      if (e) begin m_cnt = m_cnt + 1; m_fresh = 1'b0; end
      if (b) m_hit = 1'b1;
      if (bus.cmd_clr) begin m_cnt = '0; m_hit = 1'b0; end
      case (m_mode)
        RC_HALT: begin
          if (bus.cmd_halt) ;
          else if (bus.cmd_step) begin m_mode = RC_STEP; m_fresh = 1'b1; end
          else if (bus.cmd_count && bus.cnt_val != 0) begin
            m_mode = RC_COUNT; m_left = bus.cnt_val; m_fresh = 1'b1;
          end
          else if (bus.cmd_run) begin m_mode = RC_RUN; m_fresh = 1'b1; end
        end
        RC_RUN:  if (bus.cmd_halt || b) m_mode = RC_HALT;
        RC_STEP: m_mode = RC_HALT;
        default: begin
          if (e) m_left = m_left - 1;
          if (bus.cmd_halt || b || m_left == 0) m_mode = RC_HALT;
        end
      endcase
    end
  end

  // Compare every output against the model in the middle of every cycle.
  always @(negedge clk) begin
    checkOutput("cpu_en",    64'(bus.cpu_en),    64'(m_exec()));
    checkOutput("halted",    64'(bus.halted),    64'(m_mode == RC_HALT));
    checkOutput("bp_hit",    64'(bus.bp_hit),    64'(m_hit));
    checkOutput("instr_cnt", 64'(bus.instr_cnt), 64'(m_cnt));
    checkOutput("state",     64'(bus.state),     64'(m_mode));
  end

  // One clock: observe enable, take the edge, then let the "core" advance its
  // PC if it executed and drop the command pulses.
  task automatic tick();
    @(negedge clk);
    if (bus.cpu_en) en_seen++;
    @(posedge clk);
    #1;
    if (m_last_en) bus.pc = bus.pc + 32'd4;
    bus.cmd_run = 0; bus.cmd_step = 0; bus.cmd_count = 0;
    bus.cmd_halt = 0; bus.cmd_clr = 0;
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit c, input logic [CW-1:0] v,
                               input bit h, input bit clr);
    bus.cmd_run = r; bus.cmd_step = s; bus.cmd_count = c; bus.cnt_val = v;
    bus.cmd_halt = h; bus.cmd_clr = clr;
    tick();
  endtask

  task automatic wPulse(input bit s, input bit c, input logic [3:0] v, input bit h, input bit clr);
    wif.cmd_step = s; wif.cmd_count = c; wif.cnt_val = v; wif.cmd_halt = h; wif.cmd_clr = clr;
    @(posedge clk); #1;
    wif.cmd_step = 0; wif.cmd_count = 0; wif.cmd_halt = 0; wif.cmd_clr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_run = 0; bus.cmd_step = 0; bus.cmd_count = 0; bus.cnt_val = '0;
    bus.cmd_halt = 0; bus.cmd_clr = 0; bus.bp_en = 0; bus.bp_addr = '0; bus.pc = RESET_PC;
    wif.cmd_run = 0; wif.cmd_step = 0; wif.cmd_count = 0; wif.cnt_val = '0;
    wif.cmd_halt = 0; wif.cmd_clr = 0; wif.bp_en = 0; wif.bp_addr = '0; wif.pc = RESET_PC;
    #3;
    checkOutput("rst_halted",  64'(bus.halted),    64'd1);
    checkOutput("rst_cpu_en",  64'(bus.cpu_en),    64'd0);
    checkOutput("rst_cnt",     64'(bus.instr_cnt), 64'd0);
    checkOutput("rst_state_w", 64'(wif.state),     64'(RC_RUN));
    #20 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single steps");
    en_seen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, '0, 0, 0);
      tick(); tick();
      checkOutput("step_halted", 64'(bus.halted), 64'd1);
    end
    checkOutput("step_en_cycles", 64'(en_seen), 64'd3);
    checkOutput("step_cnt", 64'(bus.instr_cnt), 64'd3);

    $display("[TB] run-N");
    applyStimulus(0, 0, 0, '0, 0, 1);
    en_seen = 0;
    applyStimulus(0, 0, 1, 32'd5, 0, 0);
    repeat (6) tick();
    checkOutput("count5_en_cycles", 64'(en_seen), 64'd5);
    checkOutput("count5_cnt", 64'(bus.instr_cnt), 64'd5);
    checkOutput("count5_halted", 64'(bus.halted), 64'd1);
    en_seen = 0;
    applyStimulus(0, 0, 1, 32'd0, 0, 0);
    repeat (4) tick();
    checkOutput("count0_en_cycles", 64'(en_seen), 64'd0);
    checkOutput("count0_state", 64'(bus.state), 64'(RC_HALT));

    $display("[TB] breakpoint");
    applyStimulus(0, 0, 0, '0, 0, 1);
    bus.bp_en = 1; bus.bp_addr = 32'h3010; bus.pc = RESET_PC;
    applyStimulus(1, 0, 0, '0, 0, 0);
    repeat (8) tick();
    checkOutput("bp_halted", 64'(bus.halted), 64'd1);
    checkOutput("bp_hit", 64'(bus.bp_hit), 64'd1);
    checkOutput("bp_cnt", 64'(bus.instr_cnt), 64'd4);
    checkOutput("bp_pc", 64'(bus.pc), 64'h3010);
    applyStimulus(1, 0, 0, '0, 0, 0);
    repeat (3) tick();
    checkOutput("bp_resume_pc", 64'(bus.pc), 64'h301c);
    checkOutput("bp_resume_state", 64'(bus.state), 64'(RC_RUN));
    applyStimulus(0, 0, 0, '0, 0, 1);
    checkOutput("clr_run_cnt", 64'(bus.instr_cnt), 64'd0);
    checkOutput("clr_run_hit", 64'(bus.bp_hit), 64'd0);
    applyStimulus(0, 0, 0, '0, 1, 0);
    bus.bp_en = 0;

    $display("[TB] halt/run collision and step during run");
    applyStimulus(1, 0, 0, '0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, '0, 1, 0);
    checkOutput("halt_run_state", 64'(bus.state), 64'(RC_HALT));
    applyStimulus(1, 0, 0, '0, 0, 0);
    tick();
    applyStimulus(0, 1, 0, '0, 0, 0);
    tick();
    checkOutput("step_in_run_state", 64'(bus.state), 64'(RC_RUN));
    applyStimulus(0, 0, 0, '0, 1, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) bus.bp_en = ~bus.bp_en;
      if ($urandom_range(0, 29) == 0) bus.bp_addr = RESET_PC + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0)
        bus.pc = ($urandom_range(0, 1) == 1) ? bus.bp_addr : RESET_PC + 32'(4 * $urandom_range(0, 15));
      applyStimulus($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 6, CW'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
    end

    $display("[TB] async reset during run-N");
    bus.bp_en = 0;
    applyStimulus(0, 0, 0, '0, 1, 0);
    applyStimulus(0, 0, 1, 32'd5, 0, 0);
    tick(); tick();
    checkOutput("pre_rst_state", 64'(bus.state), 64'(RC_COUNT));
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_cpu_en", 64'(bus.cpu_en), 64'd0);
    checkOutput("async_rst_halted", 64'(bus.halted), 64'd1);
    checkOutput("async_rst_cnt", 64'(bus.instr_cnt), 64'd0);
    @(posedge clk); #3 rst = 1'b0;
    en_seen = 0;
    repeat (8) tick();
    checkOutput("post_rst_en_cycles", 64'(en_seen), 64'd0);

    $display("[TB] narrow counter wrap");
    wPulse(0, 0, 4'd0, 1, 0);
    wPulse(0, 0, 4'd0, 0, 1);
    checkOutput("w_halted", 64'(wif.halted), 64'd1);
    checkOutput("w_cleared", 64'(wif.instr_cnt), 64'd0);
    wPulse(0, 1, 4'd15, 0, 0);
    repeat (17) @(posedge clk);
    #1;
    checkOutput("w_cnt15", 64'(wif.instr_cnt), 64'd15);
    wPulse(1, 0, 4'd0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("w_wrap", 64'(wif.instr_cnt), 64'd0);
    checkOutput("w_wrap_halted", 64'(wif.halted), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run-control unit that sequences the single-cycle RISC-V core. It produces the core's per-cycle execute enable (`cpu_en`, qualifying PC and register/memory writes) and supports four modes: free run, single step, run-N-instructions, and halt. It adds a PC breakpoint that halts before the matching instruction executes and counts retired instructions for the debug bus. It sits between the board command inputs (buttons/debug host) and the core's `pc` output.

## Interface
Parameters:
- `START_RUN`, default 0: state after reset; 0 = HALT, 1 = RUN.
- `CNT_W`, default 32: width of the instruction counter and run-N counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_run`  in  1  one-cycle pulse: enter RUN.
- `cmd_step`  in  1  one-cycle pulse: execute exactly one instruction.
- `cmd_count`  in  1  one-cycle pulse: run `cnt_val` instructions.
- `cnt_val`  in  CNT_W  instruction count, sampled with `cmd_count`.
- `cmd_halt`  in  1  one-cycle pulse: stop.
- `cmd_clr`  in  1  clear `instr_cnt` and `bp_hit`.
- `bp_en`  in  1  breakpoint enable (level).
- `bp_addr`  in  32  breakpoint PC.
- `pc`  in  32  current core PC.
- `cpu_en`  out  1  core execute enable (combinational from state and breakpoint check).
- `halted`  out  1  state == HALT.
- `bp_hit`  out  1  sticky; set when the breakpoint stops execution.
- `instr_cnt`  out  CNT_W  retired instructions (cycles with `cpu_en`=1).
- `state`  out  2  encoding: HALT=0, RUN=1, STEP=2, COUNT=3.

## Operation
- **HALT.** `cpu_en`=0. Commands are accepted with priority halt > step > count > run:
  - `cmd_step` → STEP.
  - `cmd_count` with `cnt_val`≠0 → COUNT, loading `remain`=`cnt_val`.
  - `cmd_count` with `cnt_val`=0 is ignored.
  - `cmd_run` → RUN.
  - Entering any run state sets `resume`=1.
- **RUN / COUNT / STEP.** `cmd_run`, `cmd_step` and `cmd_count` are ignored. `cmd_halt` → HALT on the next edge; the instruction in the `cmd_halt` cycle still executes if `cpu_en`=1.
- **Breakpoint match.** `brk` = `bp_en` & (`pc`==`bp_addr`) & ~`resume`, evaluated in RUN and COUNT only.
  - If `brk`: `cpu_en`=0 in that cycle, next state = HALT, and `bp_hit` is set.
  - `resume` suppresses the match on the first enabled cycle after leaving HALT, so continuing from a breakpoint executes the breakpoint instruction.
- **STEP.** Always `cpu_en`=1 for one cycle (breakpoint ignored), then HALT.
- **COUNT.** Each cycle with `cpu_en`=1 decrements `remain`. When `remain`==1 and `cpu_en`=1, next state = HALT.
- **`resume`.** Cleared after any cycle with `cpu_en`=1.
- **`instr_cnt`.** +1 on every cycle with `cpu_en`=1, wrapping modulo 2^CNT_W.
- **`cmd_clr`.** Zeroes `instr_cnt` and `bp_hit`. It wins over a simultaneous increment or set.
- **Simultaneous events.** `cmd_halt` together with `brk`: both result in HALT, and `bp_hit` is set.

## Timing
- Reset (async, any time, including mid-run): state=`START_RUN`? RUN : HALT, `remain`=0, `resume`=1, `instr_cnt`=0, `bp_hit`=0.
  - Consequence: `cpu_en`=0 and `halted`=1 during reset when `START_RUN`=0.
- Command pulse at edge t (HALT) → new state and `cpu_en`=1 in cycle t+1 (1-cycle latency).
- STEP: exactly one `cpu_en` cycle (t+1); `halted`=1 from t+2.
- COUNT N: `cpu_en` high in cycles t+1 .. t+N with no breakpoint; `halted`=1 from t+N+1.
- Breakpoint: `cpu_en` drops in the same cycle `pc` matches (combinational); `halted`, `bp_hit` and `state` update on the next edge.
- `cmd_halt` at edge t in a run state: `cpu_en`=0 from cycle t+1.
- Command pulses longer than one cycle are treated as repeated pulses. They have no effect outside HALT.

## Structure
- Shared package `cpu_pkg`:
  - state encoding constants `RC_HALT`, `RC_RUN`, `RC_STEP`, `RC_COUNT`;
  - `RC_STATE_W`=2;
  - reset-PC constant 32'h3000, used by the bench.
- Single module with no sub-module. The state register, `remain` counter, `resume` flag and `instr_cnt` live in one clocked process, with combinational `cpu_en`/next-state logic.
- The debug mux maps `instr_cnt` and {`bp_hit`, `halted`, `state`} to new `chk_addr` codes.

## Test plan
- Reset with `START_RUN`=0, then `cmd_step` ×3 with gaps → `cpu_en` exactly 3 single cycles; `instr_cnt`=3; `halted`=1 after each.
- `cmd_count` with `cnt_val`=5 → 5 consecutive `cpu_en` cycles, `instr_cnt`=5, then HALT. `cmd_count` with `cnt_val`=0 → stays HALT, `cpu_en` never 1.
- `bp_en`=1, `bp_addr`=32'h3010, `cmd_run`, with `pc` advancing by 4 from 32'h3000:
  - `cpu_en`=0 when `pc`=32'h3010; HALT; `bp_hit`=1; `instr_cnt`=4.
  - Then `cmd_run` → 32'h3010 executes, and `pc` proceeds.
- RUN, then `cmd_halt` and `cmd_run` in the same cycle → HALT next cycle. `cmd_step` during RUN is ignored (state stays RUN).
- Assert `rst` asynchronously mid-COUNT (`remain`=3) → outputs immediately at reset values, with no `cpu_en` pulse after release.
- Preload `instr_cnt`=2^32−1 via run, then one step → wraps to 0. `cmd_clr` in a `cpu_en` cycle → `instr_cnt`=0 and `bp_hit`=0.
